// File: rtl/psum_port_arbiter_if.sv
// Requester and scratchpad signal bundle for the psum port arbiter.
// The arbiter takes the slave view; the requester/scratchpad side takes the master view.
interface psum_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              clr_req;
  logic              clr_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              acc_req;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output clr_req, wr_req, wr_addr, wr_data, acc_req, acc_addr, acc_data,
           rd_req, rd_addr, mem_rdata,
    input  clr_done, wr_gnt, acc_gnt, rd_gnt, rd_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  clr_req, wr_req, wr_addr, wr_data, acc_req, acc_addr, acc_data,
           rd_req, rd_addr, mem_rdata,
    output clr_done, wr_gnt, acc_gnt, rd_gnt, rd_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/psum_port_arbiter.sv
// Shares one single-port psum scratchpad between MAC writes, read-modify-write
// accumulates, drain reads and a full clear, with round-robin grants in IDLE.
module psum_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input logic                clk,
  input logic                rst,
  psum_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACC_WAIT, ACC_WR} state_e;

  localparam logic [1:0]        RR_WR     = 2'd0;
  localparam logic [1:0]        RR_ACC    = 2'd1;
  localparam logic [1:0]        RR_RD     = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] acc_addr_q;
  logic [DATA_W-1:0] acc_data_q;
  logic [DATA_W-1:0] acc_rdata_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_hold_q;
  logic [1:0]        last_q;
  logic [1:0]        last_d;

  logic              wr_gnt;
  logic              acc_gnt;
  logic              rd_gnt;
  logic              clr_go;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Psum accumulation wraps modulo 2^DATA_W; no saturation.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Grant decode: clear beats everyone, otherwise rotate after the last winner.
  always_comb begin
    wr_gnt  = 1'b0;
    acc_gnt = 1'b0;
    rd_gnt  = 1'b0;
    last_d  = last_q;
    clr_go  = !rst && (state_q == IDLE) && bus.clr_req;
    if (!rst && (state_q == IDLE) && !bus.clr_req) begin
      case (last_q)
        RR_WR: begin
          if (bus.acc_req)     acc_gnt = 1'b1;
          else if (bus.rd_req) rd_gnt  = 1'b1;
          else if (bus.wr_req) wr_gnt  = 1'b1;
        end
        RR_ACC: begin
          if (bus.rd_req)       rd_gnt  = 1'b1;
          else if (bus.wr_req)  wr_gnt  = 1'b1;
          else if (bus.acc_req) acc_gnt = 1'b1;
        end
        default: begin
          if (bus.wr_req)       wr_gnt  = 1'b1;
          else if (bus.acc_req) acc_gnt = 1'b1;
          else if (bus.rd_req)  rd_gnt  = 1'b1;
        end
      endcase
    end
    if (wr_gnt)  last_d = RR_WR;
    if (acc_gnt) last_d = RR_ACC;
    if (rd_gnt)  last_d = RR_RD;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = bus.wr_addr;
            mem_wdata = bus.wr_data;
          end else if (acc_gnt) begin
            mem_en   = 1'b1;
            mem_addr = bus.acc_addr;
          end else if (rd_gnt) begin
            mem_en   = 1'b1;
            mem_addr = bus.rd_addr;
          end
        end
        CLEAR: begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = cnt_q;
        end
        ACC_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = acc_addr_q;
          mem_wdata = wrap_add(acc_rdata_q, acc_data_q);
        end
        default: ;
      endcase
    end
  end

  // Sequencer: clear sweep and the three-cycle read/add/write accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      last_q      <= RR_RD;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
      acc_rdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      last_q     <= last_d;
      rd_valid_q <= rd_gnt;
      if (rd_valid_q) rd_hold_q <= bus.mem_rdata;
      case (state_q)
        IDLE: begin
          if (clr_go) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (acc_gnt) begin
            state_q    <= ACC_WAIT;
            busy_q     <= 1'b1;
            acc_addr_q <= bus.acc_addr;
            acc_data_q <= bus.acc_data;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACC_WAIT: begin
          acc_rdata_q <= bus.mem_rdata;
          state_q     <= ACC_WR;
        end
        ACC_WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is live from the scratchpad while valid, held otherwise.
  assign bus.rd_data   = rd_valid_q ? bus.mem_rdata : rd_hold_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.clr_done  = !rst && (state_q == CLEAR) && (cnt_q == LAST_ADDR);
  assign bus.wr_gnt    = wr_gnt;
  assign bus.acc_gnt   = acc_gnt;
  assign bus.rd_gnt    = rd_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_psum_port_arbiter.sv
// Directed and randomized checks of psum_port_arbiter against a scratchpad
// model and a grant/memory reference model.
module tb_psum_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  psum_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port scratchpad: read data appears the cycle after the command.
  logic [DW-1:0] smem [16];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) smem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= smem[bus.mem_addr];
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input string t, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    chk1({t, ".gnt"}, bus.wr_gnt, 1'b1);
    chk1({t, ".we"}, bus.mem_we, 1'b1);
    chkd({t, ".wdata"}, bus.mem_wdata, d);
    tick();
    bus.wr_req = 1'b0;
  endtask

  task automatic do_acc(input string t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] sum);
    bus.acc_req = 1'b1; bus.acc_addr = a; bus.acc_data = d;
    @(negedge clk);
    chk1({t, ".gnt"}, bus.acc_gnt, 1'b1);
    chk1({t, ".rd_we"}, bus.mem_we, 1'b0);
    chka({t, ".rd_addr"}, bus.mem_addr, a);
    tick();
    bus.acc_req = 1'b0;
    @(negedge clk);
    chk1({t, ".wait_busy"}, bus.busy, 1'b1);
    chk1({t, ".wait_noen"}, bus.mem_en, 1'b0);
    tick();
    @(negedge clk);
    chk1({t, ".wr_we"}, bus.mem_we, 1'b1);
    chka({t, ".wr_addr"}, bus.mem_addr, a);
    chkd({t, ".wr_data"}, bus.mem_wdata, sum);
    tick();
  endtask

  task automatic do_rd(input string t, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    chk1({t, ".gnt"}, bus.rd_gnt, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk1({t, ".valid"}, bus.rd_valid, 1'b1);
    chkd({t, ".data"}, bus.rd_data, exp);
    tick();
  endtask

  task automatic do_clr(input string t);
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk1({t, ".acc_nognt"}, bus.wr_gnt, 1'b0);
    chk1({t, ".acc_noen"}, bus.mem_en, 1'b0);
    tick();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chka({t, ".addr"}, bus.mem_addr, AW'(i));
      chkd({t, ".wdata"}, bus.mem_wdata, '0);
      chk1({t, ".we"}, bus.mem_we, 1'b1);
      chk1({t, ".busy"}, bus.busy, 1'b1);
      chk1({t, ".nognt"}, bus.wr_gnt, 1'b0);
      chk1({t, ".done"}, bus.clr_done, (i == 15));
      tick();
    end
  endtask

  logic [2:0]    gseq [10];
  logic [DW-1:0] vals [4];
  bit   [2:0]    rq;
  logic [AW-1:0] ra   [3];
  logic [DW-1:0] rdat [3];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] expq [$];
  int            last_m, mbusy, g;
  bit            exp_rdv;

  initial begin
    bus.clr_req = 1'b0;
    bus.wr_req = 1'b1;  bus.wr_addr = 4'd8;  bus.wr_data = '0;
    bus.acc_req = 1'b1; bus.acc_addr = 4'd9; bus.acc_data = '0;
    bus.rd_req = 1'b1;  bus.rd_addr = 4'd10;
    rst = 1'b1;

    // Reset: all outputs low even with every requester asserted.
    tick(); tick();
    @(negedge clk);
    chk1("rst.wr_gnt", bus.wr_gnt, 1'b0);
    chk1("rst.acc_gnt", bus.acc_gnt, 1'b0);
    chk1("rst.rd_gnt", bus.rd_gnt, 1'b0);
    chk1("rst.mem_en", bus.mem_en, 1'b0);
    chk1("rst.busy", bus.busy, 1'b0);
    chk1("rst.rd_valid", bus.rd_valid, 1'b0);
    chkd("rst.rd_data", bus.rd_data, '0);
    chk1("rst.clr_done", bus.clr_done, 1'b0);

    // Continuous contention: wr, acc (+2 busy), rd, wr, acc, ...
    gseq = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b001,
             3'b100, 3'b010, 3'b000, 3'b000, 3'b001};
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chkd("rr.gnt", DW'({bus.wr_gnt, bus.acc_gnt, bus.rd_gnt}), DW'(gseq[i]));
      chk1("rr.busy", bus.busy, (gseq[i] == 3'b000));
      tick();
    end
    bus.wr_req = 1'b0; bus.acc_req = 1'b0; bus.rd_req = 1'b0;

    // Clear with a write pending: clear wins, write follows immediately after.
    bus.wr_req = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hAAAA;
    do_clr("clr");
    @(negedge clk);
    chk1("clr.wr_after", bus.wr_gnt, 1'b1);
    chka("clr.wr_addr", bus.mem_addr, 4'd5);
    tick();
    bus.wr_req = 1'b0;
    do_rd("clr.rd5", 4'd5, 16'hAAAA);
    do_rd("clr.rd12", 4'd12, 16'h0000);

    do_wr("ex.wr3", 4'd3, 16'h0005);
    do_acc("ex.acc3", 4'd3, 16'h0007, 16'h000C);
    do_rd("ex.rd3", 4'd3, 16'h000C);

    do_wr("wrap.wr1", 4'd1, 16'hFFFF);
    do_acc("wrap.acc1", 4'd1, 16'h0002, 16'h0001);
    do_rd("wrap.rd1", 4'd1, 16'h0001);

    // Back-to-back reads stream out in address order, then hold.
    for (int i = 0; i < 4; i++) begin
      vals[i] = DW'(16'h1111 * (i + 1));
      do_wr("b2b.wr", AW'(i), vals[i]);
    end
    for (int k = 0; k < 5; k++) begin
      bus.rd_req = (k < 4);
      bus.rd_addr = AW'(k % 4);
      @(negedge clk);
      if (k < 4) chk1("b2b.gnt", bus.rd_gnt, 1'b1);
      chk1("b2b.valid", bus.rd_valid, (k > 0));
      if (k > 0) chkd("b2b.data", bus.rd_data, vals[k-1]);
      tick();
    end
    @(negedge clk);
    chk1("b2b.valid_lo", bus.rd_valid, 1'b0);
    chkd("b2b.hold", bus.rd_data, vals[3]);
    tick();

    // Reset during ACC_WAIT aborts the accumulate write.
    bus.acc_req = 1'b1; bus.acc_addr = 4'd6; bus.acc_data = 16'h0001;
    @(negedge clk);
    chk1("abort.acc_gnt", bus.acc_gnt, 1'b1);
    tick();
    bus.acc_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0077;
    rst = 1'b1;
    #1;
    chk1("abort.busy", bus.busy, 1'b0);
    chk1("abort.mem_en", bus.mem_en, 1'b0);
    chk1("abort.wr_gnt", bus.wr_gnt, 1'b0);
    tick();
    @(negedge clk);
    chk1("abort.no_accwr", bus.mem_en, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("abort.wr_gnt_after", bus.wr_gnt, 1'b1);
    chka("abort.wr_addr", bus.mem_addr, 4'd7);
    chkd("abort.wr_data", bus.mem_wdata, 16'h0077);
    tick();
    bus.wr_req = 1'b0;

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_clr("rclr");
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rq = '0; last_m = 2; mbusy = 0; exp_rdv = 1'b0;
    for (int k = 0; k < 3; k++) begin ra[k] = '0; rdat[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      bus.wr_req = rq[0];  bus.wr_addr = ra[0];  bus.wr_data = rdat[0];
      bus.acc_req = rq[1]; bus.acc_addr = ra[1]; bus.acc_data = rdat[1];
      bus.rd_req = rq[2];  bus.rd_addr = ra[2];
      @(negedge clk);
      g = -1;
      if (mbusy == 0) begin
        for (int k = 1; k <= 3; k++) begin
          if (g < 0 && rq[(last_m + k) % 3]) g = (last_m + k) % 3;
        end
      end
      chk1("rnd.busy", bus.busy, (mbusy > 0));
      chkd("rnd.gnt", DW'({bus.wr_gnt, bus.acc_gnt, bus.rd_gnt}),
           DW'({g == 0, g == 1, g == 2}));
      chk1("rnd.rd_valid", bus.rd_valid, exp_rdv);
      if (exp_rdv) chkd("rnd.rd_data", bus.rd_data, expq.pop_front());
      if (mbusy > 0) mbusy--;
      case (g)
        0: ref_mem[ra[0]] = rdat[0];
        1: begin ref_mem[ra[1]] = ref_mem[ra[1]] + rdat[1]; mbusy = 2; end
        2: expq.push_back(ref_mem[ra[2]]);
        default: ;
      endcase
      if (g >= 0) begin rq[g] = 1'b0; last_m = g; end
      exp_rdv = (g == 2);
      tick();
      for (int k = 0; k < 3; k++) begin
        if (!rq[k] && c < 380 && $urandom_range(1, 0) == 1) begin
          rq[k] = 1'b1;
          ra[k] = AW'($urandom_range(15, 0));
          rdat[k] = DW'($urandom);
        end
      end
    end
    chk1("rnd.drained", (expq.size() == 0 && rq == 3'b000), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
